// File: rtl/fifo_pop_arbiter_pkg.sv
// Shared types and the round-robin search helper for the FIFO pop arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } pick_t;

  // First set bit of req_vec at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      idx = (32'(ptr) + off) % n;
      if ((off < n) && !r.found && req_vec[IDX_W'(idx)]) begin
        r.found = 1'b1;
        r.index = IDX_W'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_pop_arbiter_if.sv
// Requester, FIFO pop-side and response signals of the FIFO pop arbiter.
interface fifo_pop_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 11
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic                  en;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [FIFO_WIDTH-1:0] fifo_pop_data;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [FIFO_WIDTH-1:0] rsp_data;
  logic                  busy;

  modport master (
    output en, req, fifo_empty, fifo_pop_data,
    input  gnt, fifo_pop, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  en, req, fifo_empty, fifo_pop_data,
    output gnt, fifo_pop, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/fifo_pop_arbiter_rr_arbiter.sv
// Combinational round-robin picker: eligibility mask and pointer in,
// one-hot grant and advanced pointer out.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [ID_W-1:0]    ptr,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    gnt_id_c,
  output logic [ID_W-1:0]    next_ptr_c
);

  pick_t pick;

  always_comb begin
    pick       = rr_pick(MAX_REQ'(elig), IDX_W'(ptr), NUM_REQ);
    gnt_c      = '0;
    gnt_id_c   = ID_W'(pick.index);
    next_ptr_c = ptr;
    if (grant_en && pick.found) begin
      gnt_c[gnt_id_c] = 1'b1;
      next_ptr_c      = (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
    end
  end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Shares one pipelined FIFO's pop port among NUM_REQ requesters and routes
// each returning word back to the requester that popped it.
module fifo_pop_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 11,
  parameter int unsigned NUM_LOOPS  = 3,
  parameter int unsigned MAX_OUT    = 2
) (
  input logic              clk,
  input logic              rst,
  fifo_pop_arbiter_if.slave bus
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned CRED_W = $clog2(MAX_OUT + 1);

  state_t                state;
  logic [ID_W-1:0]       rr;
  logic [ID_W-1:0]       rr_next_c;
  logic [ID_W-1:0]       gnt_id_c;
  logic [NUM_REQ-1:0]    elig_c;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [NUM_REQ-1:0]    retire_c;
  logic [CRED_W-1:0]     credit [NUM_REQ];
  tag_t                  tag_pipe [NUM_LOOPS];
  logic                  grant_en_c;
  logic                  pop_c;
  logic                  tags_valid_c;
  logic                  in_flight_c;
  logic                  rsp_valid_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [FIFO_WIDTH-1:0] rsp_data_q;

  // A response leaving this cycle frees its credit at once, so a saturated
  // requester can be re-granted in its retire cycle.
  always_comb begin
    tags_valid_c = 1'b0;
    retire_c     = '0;
    elig_c       = '0;
    for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
      tags_valid_c = tags_valid_c | tag_pipe[i].valid;
    end
    in_flight_c = tags_valid_c | rsp_valid_q;
    grant_en_c  = (state == RUN) && bus.en && !bus.fifo_empty;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      retire_c[i] = rsp_valid_q && (rsp_id_q == ID_W'(i));
      elig_c[i]   = bus.req[i] && ((credit[i] < CRED_W'(MAX_OUT)) || retire_c[i]);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .elig       (elig_c),
    .ptr        (rr),
    .grant_en   (grant_en_c),
    .gnt_c      (gnt_c),
    .gnt_id_c   (gnt_id_c),
    .next_ptr_c (rr_next_c)
  );

  assign pop_c         = |gnt_c;
  assign bus.gnt       = gnt_c;
  assign bus.fifo_pop  = pop_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state != IDLE) || in_flight_c;

  always_ff @(posedge clk or posedge rst) begin : fsm
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.en) state <= RUN;
        RUN:     if (!bus.en) state <= in_flight_c ? DRAIN : IDLE;
        DRAIN: begin
          if (bus.en)            state <= RUN;
          else if (!in_flight_c) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin : rr_ptr
    if (rst)        rr <= '0;
    else if (pop_c) rr <= rr_next_c;
  end

  always_ff @(posedge clk or posedge rst) begin : credits
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) credit[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        case ({gnt_c[i], retire_c[i]})
          2'b10:   credit[i] <= credit[i] + CRED_W'(1);
          2'b01:   credit[i] <= credit[i] - CRED_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Tag pipe mirrors the FIFO's pop-to-data latency and never stalls.
  always_ff @(posedge clk or posedge rst) begin : tags
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: pop_c, id: IDX_W'(gnt_id_c)};
      for (int unsigned i = 1; i < NUM_LOOPS; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : rsp_reg
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= tag_pipe[NUM_LOOPS-1].valid;
      if (tag_pipe[NUM_LOOPS-1].valid) begin
        rsp_id_q   <= ID_W'(tag_pipe[NUM_LOOPS-1].id);
        rsp_data_q <= bus.fifo_pop_data;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_c));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_credit_chk
    a_credit_max:   assert property (@(posedge clk) disable iff (rst)
                                     credit[g] <= CRED_W'(MAX_OUT));
    a_credit_under: assert property (@(posedge clk) disable iff (rst)
                                     !(retire_c[g] && !gnt_c[g] && (credit[g] == '0)));
  end

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Randomized and directed bench for fifo_pop_arbiter against a queue-based
// reference model of the arbiter and a behavioural pipelined FIFO.
module tb_fifo_pop_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 11;
  localparam int NUM_LOOPS  = 3;
  localparam int MAX_OUT    = 2;
  localparam int ST_IDLE    = 0;
  localparam int ST_RUN     = 1;
  localparam int ST_DRAIN   = 2;

  typedef logic [FIFO_WIDTH-1:0] word_t;
  typedef struct {
    int    id;
    word_t data;
    int    due;
  } flight_t;

  logic clk;
  logic rst;

  fifo_pop_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) bus ();

  fifo_pop_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_WIDTH (FIFO_WIDTH),
    .NUM_LOOPS  (NUM_LOOPS),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks   = 0;
  int      failures = 0;
  int      cyc      = 0;
  int      m_state;
  int      m_rr;
  int      exp_id;
  word_t   exp_data;
  flight_t fl[$];
  word_t   fifo_q[$];
  word_t   dl[NUM_LOOPS];
  int      obs_gnt[$];
  int      obs_gnt_cyc[$];
  int      obs_rsp_cyc[$];
  word_t   obs_rsp[$];
  logic    obs_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    fifo_q.delete();
    foreach (dl[j]) dl[j] = '0;
    m_state  = ST_IDLE;
    m_rr     = 0;
    exp_id   = 0;
    exp_data = '0;
  endtask

  task automatic clear_logs();
    obs_gnt.delete();
    obs_gnt_cyc.delete();
    obs_rsp.delete();
    obs_rsp_cyc.delete();
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic e, input logic [NUM_REQ-1:0] r);
    int                 pend[NUM_REQ];
    int                 win;
    int                 k;
    int                 gi;
    logic [NUM_REQ-1:0] exp_gnt;
    logic               exp_rv;
    logic               exp_busy;
    word_t              w;

    bus.en            = e;
    bus.req           = r;
    bus.fifo_empty    = (fifo_q.size() == 0);
    bus.fifo_pop_data = dl[NUM_LOOPS-1];
    #1;

    while (fl.size() != 0 && fl[0].due < cyc) void'(fl.pop_front());
    foreach (pend[i]) pend[i] = 0;
    foreach (fl[j]) if (fl[j].due > cyc) pend[fl[j].id]++;

    win = -1;
    if (m_state == ST_RUN && e && fifo_q.size() != 0) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        k = (m_rr + off) % NUM_REQ;
        if (win < 0 && r[k] && pend[k] < MAX_OUT) win = k;
      end
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;

    exp_rv = 1'b0;
    if (fl.size() != 0 && fl[0].due == cyc) begin
      exp_rv   = 1'b1;
      exp_id   = fl[0].id;
      exp_data = fl[0].data;
    end
    exp_busy = (m_state != ST_IDLE) || (fl.size() != 0);

    check_eq("gnt",       32'(bus.gnt),       32'(exp_gnt));
    check_eq("fifo_pop",  32'(bus.fifo_pop),  32'(win >= 0));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check_eq("rsp_id",    32'(bus.rsp_id),    32'(exp_id));
    check_eq("rsp_data",  32'(bus.rsp_data),  32'(exp_data));
    check_eq("busy",      32'(bus.busy),      32'(exp_busy));

    if (bus.fifo_pop) begin
      gi = 0;
      for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) gi = i;
      obs_gnt.push_back(gi);
      obs_gnt_cyc.push_back(cyc);
    end
    if (bus.rsp_valid) begin
      obs_rsp.push_back(bus.rsp_data);
      obs_rsp_cyc.push_back(cyc);
    end
    obs_busy = bus.busy;

    w = word_t'($urandom);
    if (win >= 0) begin
      w = fifo_q.pop_front();
      fl.push_back('{win, w, cyc + NUM_LOOPS + 1});
      m_rr = (win + 1) % NUM_REQ;
    end
    for (int j = NUM_LOOPS - 1; j > 0; j--) dl[j] = dl[j-1];
    dl[0] = w;

    case (m_state)
      ST_IDLE:  if (e) m_state = ST_RUN;
      ST_RUN:   if (!e) m_state = (fl.size() != 0) ? ST_DRAIN : ST_IDLE;
      default: begin
        if (e)                    m_state = ST_RUN;
        else if (fl.size() == 0)  m_state = ST_IDLE;
      end
    endcase
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst               = 1'b1;
    bus.en            = 1'b1;
    bus.req           = '1;
    bus.fifo_empty    = 1'b0;
    bus.fifo_pop_data = word_t'($urandom);
    model_reset();
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rst_gnt",       32'(bus.gnt),       32'd0);
      check_eq("rst_fifo_pop",  32'(bus.fifo_pop),  32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
      check_eq("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      check_eq("rst_busy",      32'(bus.busy),      32'd0);
      cyc++;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  int rr_exp[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
  int cred_exp[4] = '{0, 1, 4, 5};
  int wrap_exp[4] = '{2, 3, 0, 3};
  int n;

  initial begin
    rst               = 1'b1;
    bus.en            = 1'b0;
    bus.req           = '0;
    bus.fifo_empty    = 1'b1;
    bus.fifo_pop_data = '0;
    do_reset(3);

    // Round robin over a preloaded FIFO holding 1..8
    for (int v = 1; v <= 8; v++) fifo_q.push_back(word_t'(v));
    clear_logs();
    repeat (14) step(1'b1, 4'b1111);
    check_eq("rr_count", 32'(obs_gnt.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_gnt.size(); i++)
      check_eq($sformatf("rr_gnt%0d", i), 32'(obs_gnt[i]), 32'(rr_exp[i]));
    for (int i = 0; i < 8 && i < obs_rsp.size(); i++)
      check_eq($sformatf("rr_data%0d", i), 32'(obs_rsp[i]), 32'(i + 1));
    if (obs_gnt.size() >= 8)
      check_eq("rr_back_to_back", 32'(obs_gnt_cyc[7] - obs_gnt_cyc[0]), 32'd7);
    if (obs_gnt.size() != 0 && obs_rsp.size() != 0)
      check_eq("rr_latency", 32'(obs_rsp_cyc[0] - obs_gnt_cyc[0]), 32'(NUM_LOOPS + 1));

    // Empty gating, then a single push
    clear_logs();
    repeat (4) step(1'b1, 4'b0010);
    check_eq("empty_no_gnt", 32'(obs_gnt.size()), 32'd0);
    fifo_q.push_back(word_t'(11'h5A5));
    repeat (6) step(1'b1, 4'b0010);
    check_eq("push_gnt_count", 32'(obs_gnt.size()), 32'd1);
    check_eq("push_rsp_count", 32'(obs_rsp.size()), 32'd1);
    if (obs_gnt.size() == 1 && obs_rsp.size() == 1) begin
      check_eq("push_gnt_id",  32'(obs_gnt[0]), 32'd1);
      check_eq("push_rsp",     32'(obs_rsp[0]), 32'h5A5);
      check_eq("push_latency", 32'(obs_rsp_cyc[0] - obs_gnt_cyc[0]), 32'(NUM_LOOPS + 1));
    end

    // Credit limit with a single requester
    clear_logs();
    repeat (12) fifo_q.push_back(word_t'($urandom));
    repeat (12) step(1'b1, 4'b0100);
    check_eq("cred_count", 32'(obs_gnt.size()), 32'd6);
    for (int i = 1; i < 4 && i < obs_gnt_cyc.size(); i++)
      check_eq($sformatf("cred_gap%0d", i), 32'(obs_gnt_cyc[i] - obs_gnt_cyc[0]), 32'(cred_exp[i]));

    // Drain: three pops in flight, then disable
    repeat (6) step(1'b1, 4'b0000);
    repeat (4) fifo_q.push_back(word_t'($urandom));
    clear_logs();
    repeat (3) step(1'b1, 4'b1111);
    n = 0;
    do begin
      step(1'b0, 4'b1111);
      n++;
    end while (obs_busy && n < 20);
    check_eq("drain_idle",      32'(obs_busy),       32'd0);
    check_eq("drain_gnt_count", 32'(obs_gnt.size()), 32'd3);
    check_eq("drain_rsp_count", 32'(obs_rsp.size()), 32'd3);

    // Reset with two pops outstanding
    repeat (3) step(1'b1, 4'b1111);
    do_reset(2);
    repeat (4) fifo_q.push_back(word_t'($urandom));
    clear_logs();
    repeat (10) step(1'b1, 4'b1010);
    if (obs_gnt.size() != 0 && obs_rsp.size() != 0) begin
      check_eq("post_rst_first_gnt", 32'(obs_gnt[0]), 32'd1);
      check_eq("post_rst_first_rsp", 32'(obs_rsp_cyc[0] - obs_gnt_cyc[0]), 32'(NUM_LOOPS + 1));
    end else begin
      check_eq("post_rst_activity", 32'(obs_gnt.size() * obs_rsp.size()), 32'd1);
    end

    // Pointer wrap from the top index
    repeat (6) step(1'b1, 4'b0000);
    repeat (4) fifo_q.push_back(word_t'($urandom));
    clear_logs();
    step(1'b1, 4'b0100);
    repeat (3) step(1'b1, 4'b1001);
    check_eq("wrap_count", 32'(obs_gnt.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_gnt.size(); i++)
      check_eq($sformatf("wrap_gnt%0d", i), 32'(obs_gnt[i]), 32'(wrap_exp[i]));

    // Random traffic with occasional disables and resets
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1 + int'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 2) != 0) fifo_q.push_back(word_t'($urandom));
        step($urandom_range(0, 9) != 0, NUM_REQ'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
